// File: rtl/avs_csr_pkg.sv
// Shared definitions for the Avalon-MM CSR block: register word offsets,
// CTRL / IRQ bit positions, the unmapped-read pattern and the default ID.
package avs_csr_pkg;

    // Word offsets decoded from address bits [2:0]
    localparam logic [2:0] ADDR_ID         = 3'd0;
    localparam logic [2:0] ADDR_SCRATCH    = 3'd1;
    localparam logic [2:0] ADDR_CTRL       = 3'd2;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd3;
    localparam logic [2:0] ADDR_IRQ_SET    = 3'd4;
    localparam logic [2:0] ADDR_TMR_LOAD   = 3'd5;
    localparam logic [2:0] ADDR_TMR_COUNT  = 3'd6;
    localparam logic [2:0] ADDR_UNMAPPED   = 3'd7;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN_BIT = 0;
    localparam int CTRL_TMR_EN_BIT = 1;

    // IRQ_STATUS / IRQ_SET bit positions
    localparam int IRQ_TMR_BIT = 0;
    localparam int IRQ_SW_BIT  = 1;

    localparam logic [31:0] UNMAPPED_DATA    = 32'hDEAD_BEEF;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5C5_0001;

    // A word address hits a register only when the upper bits are clear
    // and the low offset is not the hole at 7.
    function automatic logic addr_is_mapped(input logic [31:0] addr);
        return (addr[31:3] == 29'd0) && (addr[2:0] != ADDR_UNMAPPED);
    endfunction

endpackage

// File: rtl/avs_csr_timer.sv
// Down-counting interval timer. Counts down while enabled; when the count
// sits at zero it pulses o_expire and reloads. A load strobe overrides the
// count immediately. Only instantiated when AVS_CSR_TIMER_EN is defined.
module avs_csr_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic [31:0] o_count,
    output logic        o_expire
);

    logic [31:0] r_count;

    // Expiry is the enabled cycle in which the count is already zero,
    // so a reload value of 0 expires on every enabled cycle.
    assign o_expire = i_en & (r_count == 32'd0);
    assign o_count  = r_count;

    // Count register: load strobe or expiry reloads, otherwise decrement while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'd0;
        end else if (i_load || o_expire) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count - 32'd1;
        end
    end

endmodule

// File: rtl/avs_csr_regs.sv
// Avalon-MM CSR slave: ID, scratch, control, W1C interrupt status with
// software set, optional interval timer, and a READ_LATENCY-deep read
// return pipeline. Define AVS_CSR_TIMER_EN to build the timer; without it
// TMR_LOAD / TMR_COUNT read 0, CTRL.TMR_EN reads 0 and IRQ_STATUS.TMR
// never sets.
module avs_csr_regs
    import avs_csr_pkg::*;
#(
    parameter int          READ_LATENCY = 1,   // legal range 1..4
    parameter logic [31:0] ID_VALUE     = ID_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avs_csr_address,
    input  logic        avs_csr_write,
    input  logic [31:0] avs_csr_writedata,
    input  logic        avs_csr_read,
    output logic [31:0] avs_csr_readdata,
    output logic        avs_csr_readdatavalid,
    output logic        irq
);

    logic        w_mapped;
    logic [2:0]  w_offset;
    logic        w_wr_en;
    logic        w_wr_scratch;
    logic        w_wr_ctrl;
    logic        w_wr_irq_status;
    logic        w_wr_irq_set;
    logic [31:0] w_rdata;
    logic [1:0]  w_status_set;
    logic [1:0]  w_status_clr;
    logic [31:0] w_tmr_count;
    logic [31:0] w_tmr_load_rd;
    logic        w_tmr_expire;

    logic [31:0] r_scratch;
    logic [1:0]  r_ctrl;
    logic [1:0]  r_irq_status;
    logic        r_irq;
    logic [31:0] r_pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pipe_valid;

    assign w_mapped        = addr_is_mapped(avs_csr_address);
    assign w_offset        = avs_csr_address[2:0];
    assign w_wr_en         = avs_csr_write & w_mapped;
    assign w_wr_scratch    = w_wr_en && (w_offset == ADDR_SCRATCH);
    assign w_wr_ctrl       = w_wr_en && (w_offset == ADDR_CTRL);
    assign w_wr_irq_status = w_wr_en && (w_offset == ADDR_IRQ_STATUS);
    assign w_wr_irq_set    = w_wr_en && (w_offset == ADDR_IRQ_SET);

`ifdef AVS_CSR_TIMER_EN
    localparam logic [1:0] CTRL_WMASK       = 2'b11;
    localparam logic [1:0] STATUS_SET_MASK  = 2'b11;

    logic        w_wr_tmr_load;
    logic [31:0] w_tmr_load_val;
    logic [31:0] r_tmr_load;

    assign w_wr_tmr_load = w_wr_en && (w_offset == ADDR_TMR_LOAD);
    // A TMR_LOAD write must reach the counter in the same edge as the register
    assign w_tmr_load_val = w_wr_tmr_load ? avs_csr_writedata : r_tmr_load;
    assign w_tmr_load_rd  = r_tmr_load;

    // TMR_LOAD reload-value register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_load <= 32'd0;
        end else if (w_wr_tmr_load) begin
            r_tmr_load <= avs_csr_writedata;
        end
    end

    avs_csr_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (r_ctrl[CTRL_TMR_EN_BIT]),
        .i_load     (w_wr_tmr_load),
        .i_load_val (w_tmr_load_val),
        .o_count    (w_tmr_count),
        .o_expire   (w_tmr_expire)
    );
`else
    // Without the timer, TMR_EN is not storable and the TMR status bit is dead
    localparam logic [1:0] CTRL_WMASK       = 2'b01;
    localparam logic [1:0] STATUS_SET_MASK  = 2'b10;

    assign w_tmr_count   = 32'd0;
    assign w_tmr_load_rd = 32'd0;
    assign w_tmr_expire  = 1'b0;
`endif

    // Status set/clear sources; set is OR-ed in after clear so set wins
    always_comb begin
        w_status_set = 2'b00;
        if (w_wr_irq_set) begin
            w_status_set = avs_csr_writedata[1:0];
        end
        w_status_set[IRQ_TMR_BIT] = w_status_set[IRQ_TMR_BIT] | w_tmr_expire;
        w_status_set = w_status_set & STATUS_SET_MASK;
        w_status_clr = w_wr_irq_status ? avs_csr_writedata[1:0] : 2'b00;
    end

    // Host-writable registers and the registered interrupt output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch    <= 32'd0;
            r_ctrl       <= 2'b00;
            r_irq_status <= 2'b00;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_scratch) begin
                r_scratch <= avs_csr_writedata;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= avs_csr_writedata[1:0] & CTRL_WMASK;
            end
            r_irq_status <= (r_irq_status & ~w_status_clr) | w_status_set;
            r_irq        <= r_ctrl[CTRL_IRQ_EN_BIT] & (|r_irq_status);
        end
    end

    // Read mux over current (pre-write) register contents
    always_comb begin
        w_rdata = 32'd0;
        if (!w_mapped) begin
            w_rdata = UNMAPPED_DATA;
        end else begin
            case (w_offset)
                ADDR_ID:         w_rdata = ID_VALUE;
                ADDR_SCRATCH:    w_rdata = r_scratch;
                ADDR_CTRL:       w_rdata = {30'd0, r_ctrl};
                ADDR_IRQ_STATUS: w_rdata = {30'd0, r_irq_status};
                ADDR_TMR_LOAD:   w_rdata = w_tmr_load_rd;
                ADDR_TMR_COUNT:  w_rdata = w_tmr_count;
                default:         w_rdata = 32'd0;
            endcase
        end
    end

    // Read return pipeline; data is zeroed in bubbles so idle readdata is 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data[i] <= 32'd0;
            end
        end else begin
            r_pipe_valid[0] <= avs_csr_read;
            r_pipe_data[0]  <= avs_csr_read ? w_rdata : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_data[i]  <= r_pipe_data[i-1];
            end
        end
    end

    assign avs_csr_readdata      = r_pipe_data[READ_LATENCY-1];
    assign avs_csr_readdatavalid = r_pipe_valid[READ_LATENCY-1];
    assign irq                   = r_irq;

endmodule

// File: tb/tb_avs_csr_regs.sv
// Self-checking bench for avs_csr_regs. Directed scenarios plus a random
// run checked against a register-map model. Works with or without
// AVS_CSR_TIMER_EN.
module tb_avs_csr_regs;

    localparam int          LAT = 2;
    localparam logic [31:0] ID  = 32'hA5C5_0001;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
`ifdef AVS_CSR_TIMER_EN
    localparam bit HAS_TMR = 1'b1;
`else
    localparam bit HAS_TMR = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr  = 32'd0;
    logic        wr    = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        rd    = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    avs_csr_regs #(.READ_LATENCY(LAT), .ID_VALUE(ID)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .avs_csr_address       (addr),
        .avs_csr_write         (wr),
        .avs_csr_writedata     (wdata),
        .avs_csr_read          (rd),
        .avs_csr_readdata      (rdata),
        .avs_csr_readdatavalid (rvalid),
        .irq                   (irq)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Cycle stamp and read-return monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } pulse_t;

    pulse_t obs_q[$];
    pulse_t exp_q[$];
    pulse_t mon_p;
    int     zero_viol = 0;

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            mon_p.cyc  = cyc;
            mon_p.data = rdata;
            obs_q.push_back(mon_p);
        end else if (rdata !== 32'd0) begin
            zero_viol = zero_viol + 1;
        end
    end

    // Register-map model
    logic [31:0] m_scratch, m_load, m_count;
    logic [1:0]  m_ctrl, m_status;
    logic        m_irq;

    task automatic model_reset();
        m_scratch = 0; m_load = 0; m_count = 0;
        m_ctrl = 0; m_status = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:3] != 0 || a[2:0] == 3'd7) return BEEF;
        case (a[2:0])
            3'd0: return ID;
            3'd1: return m_scratch;
            3'd2: return {30'd0, m_ctrl};
            3'd3: return {30'd0, m_status};
            3'd5: return m_load;
            3'd6: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic       hit;
        logic       expire;
        logic [1:0] set_b, clr_b;
        logic [31:0] n_count;
        hit    = w && (a[31:3] == 0) && (a[2:0] != 3'd7);
        expire = HAS_TMR && m_ctrl[1] && (m_count == 0);
        set_b  = 2'b00;
        clr_b  = 2'b00;
        if (hit && a[2:0] == 3'd4) set_b = d[1:0];
        if (!HAS_TMR) set_b[0] = 1'b0;
        if (expire) set_b[0] = 1'b1;
        if (hit && a[2:0] == 3'd3) clr_b = d[1:0];
        n_count = m_count;
        if (HAS_TMR) begin
            if (hit && a[2:0] == 3'd5) n_count = d;
            else if (m_ctrl[1]) n_count = (m_count == 0) ? m_load : m_count - 1;
        end
        m_irq   = m_ctrl[0] && (m_status != 0);
        m_status = (m_status & ~clr_b) | set_b;
        m_count = n_count;
        if (HAS_TMR && hit && a[2:0] == 3'd5) m_load = d;
        if (hit && a[2:0] == 3'd2) m_ctrl = HAS_TMR ? d[1:0] : {1'b0, d[0]};
        if (hit && a[2:0] == 3'd1) m_scratch = d;
    endtask

    // One bus cycle: drive, clock, update model
    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        pulse_t e;
        wr = w; rd = r; addr = a; wdata = d;
        if (r) begin
            e.cyc  = cyc + LAT;
            e.data = model_read(a);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        model_update(w, a, d);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic bit get_pulse(output pulse_t p);
        p.cyc = -1; p.data = 32'hx;
        if (obs_q.size() == 0) return 1'b0;
        p = obs_q.pop_front();
        return 1'b1;
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst_n = 1'b1;
        model_reset();
        idle(2);
        $display("test_reset done");
    endtask

    task automatic test_id_read();
        pulse_t p; bit ok; int c;
        obs_q.delete(); exp_q.delete();
        c = cyc;
        step(1'b0, 1'b1, 32'd0, 32'd0);
        idle(LAT + 1);
        ok = get_pulse(p);
        n_vec++; if (!ok) begin n_err++; $display("FAIL id_pulse: got none expected one pulse"); end
        n_vec++; if (p.data !== ID) begin n_err++; $display("FAIL id_data: got %h expected %h", p.data, ID); end
        n_vec++; if (p.cyc != c + LAT) begin n_err++; $display("FAIL id_latency: got cycle %0d expected %0d", p.cyc, c + LAT); end
        exp_q.delete();
        $display("test_id_read: data %h at cycle %0d", p.data, p.cyc);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        pulse_t p; bit ok; int c;
        exp_d[0] = 32'h1234_5678; exp_d[1] = BEEF; exp_d[2] = ID;
        obs_q.delete(); exp_q.delete();
        step(1'b1, 1'b0, 32'd1, 32'h1234_5678);
        c = cyc;
        step(1'b0, 1'b1, 32'd1, 32'd0);
        step(1'b0, 1'b1, 32'd9, 32'd0);
        step(1'b0, 1'b1, 32'd0, 32'd0);
        idle(LAT + 1);
        for (int i = 0; i < 3; i++) begin
            ok = get_pulse(p);
            n_vec++; if (!ok || p.data !== exp_d[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", i, p.data, exp_d[i]); end
            n_vec++; if (p.cyc != c + i + LAT) begin n_err++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, p.cyc, c + i + LAT); end
            $display("test_back_to_back: read %0d data %h cycle %0d", i, p.data, p.cyc);
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL b2b_extra: got %0d extra pulses expected 0", obs_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_read_write_same_cycle();
        pulse_t p; bit ok;
        obs_q.delete(); exp_q.delete();
        step(1'b1, 1'b0, 32'd1, 32'h1111_0000);
        step(1'b1, 1'b1, 32'd1, 32'h2222_0001);
        step(1'b0, 1'b1, 32'd1, 32'd0);
        idle(LAT + 1);
        ok = get_pulse(p);
        n_vec++; if (!ok || p.data !== 32'h1111_0000) begin n_err++; $display("FAIL rw_old: got %h expected 11110000", p.data); end
        ok = get_pulse(p);
        n_vec++; if (!ok || p.data !== 32'h2222_0001) begin n_err++; $display("FAIL rw_new: got %h expected 22220001", p.data); end
        exp_q.delete();
        $display("test_read_write_same_cycle done");
    endtask

    task automatic test_irq_sw();
        pulse_t p; bit ok;
        obs_q.delete(); exp_q.delete();
        step(1'b1, 1'b0, 32'd2, 32'd0);
        step(1'b1, 1'b0, 32'd3, 32'd3);
        step(1'b1, 1'b0, 32'd4, 32'd2);
        step(1'b0, 1'b1, 32'd3, 32'd0);
        idle(LAT + 1);
        ok = get_pulse(p);
        n_vec++; if (!ok || p.data !== 32'd2) begin n_err++; $display("FAIL irqsw_status: got %h expected 00000002", p.data); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irqsw_masked: got %b expected 0", irq); end
        step(1'b1, 1'b0, 32'd2, 32'd1);
        idle(1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irqsw_enabled: got %b expected 1", irq); end
        exp_q.delete();
        $display("test_irq_sw done");
    endtask

`ifdef AVS_CSR_TIMER_EN
    task automatic test_timer();
        logic [10:0] pat;
        pat = 11'b100_0110_0000;   // bit i-1 = irq after edge Ei
        step(1'b1, 1'b0, 32'd2, 32'd0);
        step(1'b1, 1'b0, 32'd5, 32'd4);
        step(1'b1, 1'b0, 32'd3, 32'd3);
        step(1'b1, 1'b0, 32'd2, 32'd3);
        idle(1);
        step(1'b1, 1'b0, 32'd5, 32'd4);
        for (int i = 1; i <= 11; i++) begin
            if (i == 7) step(1'b1, 1'b0, 32'd3, 32'd1);
            else        step(1'b0, 1'b0, 32'd0, 32'd0);
            n_vec++; if (irq !== pat[i-1]) begin n_err++; $display("FAIL timer_irq_e%0d: got %b expected %b", i, irq, pat[i-1]); end
            $display("test_timer: edge %0d irq %b", i, irq);
        end
        step(1'b1, 1'b0, 32'd2, 32'd0);
        step(1'b1, 1'b0, 32'd3, 32'd3);
    endtask

    task automatic test_expire_w1c();
        pulse_t p; bit ok;
        obs_q.delete(); exp_q.delete();
        step(1'b1, 1'b0, 32'd5, 32'd0);
        step(1'b1, 1'b0, 32'd2, 32'd3);
        step(1'b1, 1'b0, 32'd3, 32'd1);
        step(1'b0, 1'b1, 32'd3, 32'd0);
        step(1'b1, 1'b0, 32'd2, 32'd0);
        idle(LAT + 1);
        ok = get_pulse(p);
        n_vec++; if (!ok || p.data[0] !== 1'b1) begin n_err++; $display("FAIL expire_w1c: got %h expected bit0 set", p.data); end
        step(1'b1, 1'b0, 32'd3, 32'd3);
        exp_q.delete(); obs_q.delete();
        $display("test_expire_w1c: status %h", p.data);
    endtask
`else
    task automatic test_no_timer();
        logic [31:0] exp_d [4];
        logic [31:0] a_list [4];
        pulse_t p; bit ok;
        exp_d[0] = 32'd1; exp_d[1] = 32'd0; exp_d[2] = 32'd0; exp_d[3] = 32'd0;
        a_list[0] = 32'd2; a_list[1] = 32'd5; a_list[2] = 32'd6; a_list[3] = 32'd3;
        obs_q.delete(); exp_q.delete();
        step(1'b1, 1'b0, 32'd3, 32'd3);
        step(1'b1, 1'b0, 32'd2, 32'd3);
        step(1'b1, 1'b0, 32'd5, 32'd7);
        step(1'b1, 1'b0, 32'd4, 32'd1);
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, a_list[i], 32'd0);
        idle(LAT + 1);
        for (int i = 0; i < 4; i++) begin
            ok = get_pulse(p);
            n_vec++; if (!ok || p.data !== exp_d[i]) begin n_err++; $display("FAIL notimer_addr%0d: got %h expected %h", a_list[i], p.data, exp_d[i]); end
        end
        step(1'b1, 1'b0, 32'd2, 32'd0);
        exp_q.delete();
        $display("test_no_timer done");
    endtask
`endif

    task automatic test_random();
        pulse_t p, e; bit ok;
        logic w, r;
        logic [31:0] a, d;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            w = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 7);
            if (a == 32'd5) d = $urandom_range(0, 6);
            else d = $urandom;
            step(w, r, a, d);
            n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq step %0d: got %b expected %b", i, irq, m_irq); end
        end
        idle(LAT + 1);
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = get_pulse(p);
            n_vec++;
            if (!ok || p.data !== e.data || p.cyc != e.cyc) begin
                n_err++;
                $display("FAIL rand_read: got %h at cycle %0d expected %h at cycle %0d", p.data, p.cyc, e.data, e.cyc);
            end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rand_extra: got %0d extra pulses expected 0", obs_q.size()); end
        $display("test_random done");
    endtask

    task automatic test_reset_inflight();
        obs_q.delete(); exp_q.delete();
        step(1'b0, 1'b1, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL inflight_rdata: got %h expected 00000000", rdata); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL inflight_rvalid: got %b expected 0", rvalid); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL inflight_irq: got %b expected 0", irq); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        idle(LAT + 3);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL inflight_pulse: got %0d pulses expected 0", obs_q.size()); end
        $display("test_reset_inflight done");
    endtask

    task automatic test_idle_zero();
        n_vec++; if (zero_viol != 0) begin n_err++; $display("FAIL idle_rdata_zero: got %0d nonzero idle samples expected 0", zero_viol); end
        $display("test_idle_zero done");
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_back_to_back();
        test_read_write_same_cycle();
        test_irq_sw();
`ifdef AVS_CSR_TIMER_EN
        test_timer();
        test_expire_w1c();
`else
        test_no_timer();
`endif
        test_random();
        test_reset_inflight();
        test_idle_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/avs_csr_regs.md
AVS_CSR_REGS -- requirements
Module: avs_csr_regs

Interface
REQ-001 Parameter READ_LATENCY, default 1, is the cycles from an accepted avs_csr_read to avs_csr_readdatavalid; legal range 1..4.
REQ-002 Parameter ID_VALUE, default 32'hA5C5_0001, is the constant returned by the ID register.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port avs_csr_address, input, 32: word address from the Avalon master.
REQ-006 Port avs_csr_write, input, 1: write strobe, one cycle per write.
REQ-007 Port avs_csr_writedata, input, 32: write data.
REQ-008 Port avs_csr_read, input, 1: read strobe, one cycle per read.
REQ-009 Port avs_csr_readdata, output, 32: read data, valid only while avs_csr_readdatavalid is high.
REQ-010 Port avs_csr_readdatavalid, output, 1: one-cycle pulse per accepted read.
REQ-011 Port irq, output, 1: level interrupt to the master.

Function
REQ-012 Register map by word address: 0 ID (RO); 1 SCRATCH (RW); 2 CTRL (RW; bit0 IRQ_EN, bit1 TMR_EN, other bits read 0); 3 IRQ_STATUS (W1C; bit0 TMR, bit1 SW); 4 IRQ_SET (WO; write 1 sets the matching status bit; reads 0); 5 TMR_LOAD (RW); 6 TMR_COUNT (RO).
REQ-013 Address decode uses bits [2:0]. If bits [31:3] are non-zero or the word address is 7, the access is unmapped.
REQ-014 Unmapped writes are ignored. Unmapped reads return 32'hDEAD_BEEF with a normal readdatavalid pulse.
REQ-015 Writes take effect on the clock edge where avs_csr_write is high. No acknowledge is generated.
REQ-016 Reads sample register contents in the cycle avs_csr_read is high. A READ_LATENCY-deep pipeline carries data and valid, so the pulse appears exactly READ_LATENCY cycles later.
REQ-017 Back-to-back reads, one per cycle, are accepted. Each read produces its own valid pulse, in order.
REQ-018 If read and write are both high in the same cycle, the read returns the pre-write value and the write still completes.
REQ-019 readdata is 0 whenever readdatavalid is 0.
REQ-020 Timer behaviour while TMR_EN=1:
- TMR_COUNT decrements by 1 per cycle.
- On reaching 0: set IRQ_STATUS.TMR and reload from TMR_LOAD on the next cycle.
- TMR_LOAD=0 sets TMR every cycle.
REQ-021 Writing TMR_LOAD also loads TMR_COUNT immediately. Clearing TMR_EN freezes TMR_COUNT.
REQ-022 Status set and W1C clear of the same bit in the same cycle: set wins.
REQ-023 irq = IRQ_EN & (|IRQ_STATUS), registered, so it rises one cycle after the status bit sets.

Reset
REQ-024 On rst_n low, all registers, the pipeline and the timer go to 0 asynchronously: avs_csr_readdata=0, avs_csr_readdatavalid=0, irq=0.
REQ-025 Reads in flight when reset asserts are discarded; no valid pulse follows reset release.

Configuration
REQ-026 Macro AVS_CSR_TIMER_EN.
- Defined: the timer of REQ-020/021 is built.
- Undefined: no timer logic; TMR_LOAD and TMR_COUNT read 0 and ignore writes; CTRL.TMR_EN reads 0; IRQ_STATUS.TMR never sets.

Structure
REQ-027 Package avs_csr_pkg holds the register offsets, CTRL and IRQ bit positions, the 32'hDEAD_BEEF constant and the default ID_VALUE.
REQ-028 The timer is a sub-module avs_csr_timer (enable, load strobe, load value, count out, expiry pulse), instantiated only under AVS_CSR_TIMER_EN.

Verification
REQ-029 Reset release, then read addr 0 -> readdatavalid exactly READ_LATENCY cycles later with data 32'hA5C5_0001.
REQ-030 Write SCRATCH 32'h1234_5678, then 3 back-to-back reads of addresses 1, 9, 0 -> three consecutive valid pulses with 32'h1234_5678, 32'hDEAD_BEEF, ID.
REQ-031 CTRL=3, TMR_LOAD=4 -> IRQ_STATUS.TMR sets 5 cycles after the load write and irq rises 1 cycle later; W1C of 1 drops irq; timer repeats every 5 cycles.
REQ-032 Write IRQ_SET=2 with IRQ_EN=0 -> status reads 2 and irq stays 0; then CTRL=1 -> irq=1.
REQ-033 Timer expiry coincident with a W1C of bit0 -> bit0 remains set.
REQ-034 Issue a read, then assert rst_n low before the valid pulse -> no valid pulse ever appears; all outputs 0.
